// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result bundle for pipelined_cla_addsub.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_cla_addsub_if #(
   parameter int WIDTH = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_A;
   logic [WIDTH-1:0] i_B;
   logic             i_Cin;
   logic             i_sub;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_Sum;
   logic             o_Cout;
   logic             o_Ovf;

   modport master (
      output i_valid, i_A, i_B, i_Cin, i_sub, i_ready,
      input  o_ready, o_valid, o_Sum, o_Cout, o_Ovf
   );

   modport slave (
      input  i_valid, i_A, i_B, i_Cin, i_sub, i_ready,
      output o_ready, o_valid, o_Sum, o_Cout, o_Ovf
   );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// One BLOCK-wide lookahead slice per stage; slice k is resolved in stage k.
// Each stage carries the finished low sum bits, the slice carry, the operand
// bits still to be processed and the two sign bits needed for overflow.
// A single advance enable moves the whole pipe (bubbles included) or freezes it.
module pipelined_cla_addsub #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   pipelined_cla_addsub_if.slave io_bus
);
   localparam int STAGES = WIDTH / BLOCK;

   // Flat sum-of-products carries: c[i] = G[i-1:0] | P[i-1:0] & cin, no ripple.
   function automatic logic [BLOCK:0] cla_carries(
      input logic [BLOCK-1:0] g,
      input logic [BLOCK-1:0] p,
      input logic             cin
   );
      logic [BLOCK:0] c;
      logic           term;
      c = '0;
      for (int i = 0; i <= BLOCK; i++) begin
         term = cin;
         for (int j = 0; j < i; j++) term = term & p[j];
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) term = term & p[m];
            c[i] = c[i] | term;
         end
      end
      return c;
   endfunction

   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;

   logic             r_valid [STAGES];
   logic             r_carry [STAGES];
   logic             r_sa    [STAGES];
   logic             r_sb    [STAGES];
   logic [WIDTH-1:0] r_sum   [STAGES];

   // Subtraction is A + ~B + ~borrow, so Cout=1 means "no borrow".
   assign w_b_eff = io_bus.i_sub ? ~io_bus.i_B : io_bus.i_B;
   assign w_c0    = io_bus.i_sub ? ~io_bus.i_Cin : io_bus.i_Cin;

   assign w_adv          = !r_valid[STAGES-1] || io_bus.i_ready;
   assign io_bus.o_ready = w_adv;
   assign io_bus.o_valid = r_valid[STAGES-1];
   assign io_bus.o_Sum   = r_sum[STAGES-1];
   assign io_bus.o_Cout  = r_carry[STAGES-1];
   assign io_bus.o_Ovf   = (r_sa[STAGES-1] == r_sb[STAGES-1]) &&
                           (r_sum[STAGES-1][WIDTH-1] != r_sa[STAGES-1]);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * BLOCK;
      localparam int RW = WIDTH - LO - BLOCK;

      logic [BLOCK-1:0] w_a;
      logic [BLOCK-1:0] w_b;
      logic [BLOCK-1:0] w_g;
      logic [BLOCK-1:0] w_p;
      logic [BLOCK-1:0] w_s;
      logic [BLOCK:0]   w_c;
      logic             w_cin;
      logic             w_vin;
      logic             w_sa;
      logic             w_sb;
      logic [WIDTH-1:0] w_sum_in;

      if (k == 0) begin : g_src
         assign w_a      = io_bus.i_A[BLOCK-1:0];
         assign w_b      = w_b_eff[BLOCK-1:0];
         assign w_cin    = w_c0;
         assign w_vin    = io_bus.i_valid;
         assign w_sa     = io_bus.i_A[WIDTH-1];
         assign w_sb     = w_b_eff[WIDTH-1];
         assign w_sum_in = '0;
      end else begin : g_src
         assign w_a      = g_stage[k-1].g_ops.r_a[BLOCK-1:0];
         assign w_b      = g_stage[k-1].g_ops.r_b[BLOCK-1:0];
         assign w_cin    = r_carry[k-1];
         assign w_vin    = r_valid[k-1];
         assign w_sa     = r_sa[k-1];
         assign w_sb     = r_sb[k-1];
         assign w_sum_in = r_sum[k-1];
      end

      assign w_g = w_a & w_b;
      assign w_p = w_a ^ w_b;
      assign w_c = cla_carries(w_g, w_p, w_cin);
      assign w_s = w_p ^ w_c[BLOCK-1:0];

      // Latch this slice's result together with the beat's valid and sign bits
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_valid[k] <= 1'b0;
            r_carry[k] <= 1'b0;
            r_sa[k]    <= 1'b0;
            r_sb[k]    <= 1'b0;
            r_sum[k]   <= '0;
         end else if (w_adv) begin
            r_valid[k] <= w_vin;
            r_carry[k] <= w_c[BLOCK];
            r_sa[k]    <= w_sa;
            r_sb[k]    <= w_sb;
            r_sum[k]   <= w_sum_in | (WIDTH'(w_s) << LO);
         end
      end

      // The last stage has no operand bits left to forward
      if (RW > 0) begin : g_ops
         logic [RW-1:0] r_a;
         logic [RW-1:0] r_b;
         logic [RW-1:0] w_a_hi;
         logic [RW-1:0] w_b_hi;

         if (k == 0) begin : g_hi
            assign w_a_hi = io_bus.i_A[WIDTH-1:BLOCK];
            assign w_b_hi = w_b_eff[WIDTH-1:BLOCK];
         end else begin : g_hi
            assign w_a_hi = g_stage[k-1].g_ops.r_a[WIDTH-LO-1:BLOCK];
            assign w_b_hi = g_stage[k-1].g_ops.r_b[WIDTH-LO-1:BLOCK];
         end

         // Forward the operand bits that later slices still have to add
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a_hi;
               r_b <= w_b_hi;
            end
         end
      end
   end
endmodule
